// File: rtl/keypad_scan_q_if.sv
// Event stream between the keypad scanner and its consumer.
// The master side presents the FIFO head; the slave side accepts it.
interface keypad_scan_q_if #(
    parameter int CW = 4
);
    logic          ev_valid;
    logic          ev_ready;
    logic [CW-1:0] ev_code;
    logic [1:0]    ev_kind;

    modport master (
        output ev_valid,
        output ev_code,
        output ev_kind,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_code,
        input  ev_kind,
        output ev_ready
    );
endinterface

// File: rtl/keypad_scan_q.sv
// Matrix keypad scanner with per-key debounce, auto-repeat
// on the last pressed key and a first-word-fall-through event FIFO.
module keypad_scan_q #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SCAN_DIV   = 64,
    parameter int DEB_SCANS  = 4,
    parameter int REP_DELAY  = 32,
    parameter int REP_RATE   = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int REL_EVENTS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [ROWS-1:0]      rkey,
    input  logic [COLS-1:0]      ckey,
    input  logic                 repeat_en,
    input  logic                 clr_ovf,
    keypad_scan_q_if.master      ev,
    output logic [ROWS*COLS-1:0] key_down,
    output logic                 overflow
);
    localparam int NK   = ROWS * COLS;
    localparam int CW   = $clog2(NK);
    localparam int SW   = $clog2(SCAN_DIV);
    localparam int RW   = $clog2(ROWS);
    localparam int KW   = $clog2(COLS);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int LAT  = SCAN_DIV - COLS - 2;
    localparam int RMAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
    localparam int PW   = $clog2(RMAX + 1);

    typedef struct packed {
        logic [CW-1:0] code;
        logic [1:0]    kind;
    } ev_t;

    logic [SW-1:0]   slot;
    logic [RW-1:0]   row;
    logic            act;
    logic [COLS-1:0] sync1;
    logic [COLS-1:0] sync2;
    logic [COLS-1:0] lat;
    logic [3:0]      deb [NK];

    logic [CW-1:0]   rep_key;
    logic            rep_act;
    logic            rep_ph;
    logic [PW-1:0]   rep_cnt;

    ev_t             mem [FIFO_DEPTH];
    logic [AW-1:0]   wp;
    logic [AW-1:0]   rp;
    logic [AW:0]     cnt;

    logic            proc;
    logic [KW-1:0]   pcol;
    logic [CW-1:0]   pk;
    logic            raw;
    logic            cur;
    logic            chg;
    logic            tgl;
    logic            rep_step;
    logic            rep_hit;
    logic [PW-1:0]   rep_tgt;
    logic            push;
    ev_t             push_ev;
    logic            full;
    logic            pop;
    logic            wr;

    // Row slot timing; rkey follows the row index once scanning starts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot <= '0;
            row  <= '0;
            act  <= 1'b0;
        end else begin
            act <= 1'b1;
            if (slot == SW'(SCAN_DIV - 1)) begin
                slot <= '0;
                row  <= (row == RW'(ROWS - 1)) ? '0 : row + 1'b1;
            end else begin
                slot <= slot + 1'b1;
            end
        end
    end

    assign rkey = act ? ~(ROWS'(1) << row) : '1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '1;
            sync2 <= '1;
            lat   <= '0;
        end else begin
            sync1 <= ckey;
            sync2 <= sync1;
            if (act && slot == SW'(LAT))
                lat <= ~sync2;
        end
    end

    // One column of the current row is examined per cycle after the latch.
    assign proc = act && (slot > SW'(LAT)) && (slot <= SW'(LAT + COLS));

    always_comb begin
        pcol     = KW'(slot - SW'(LAT + 1));
        pk       = CW'(int'(row) * COLS + int'(pcol));
        raw      = lat[pcol];
        cur      = key_down[pk];
        chg      = proc && (raw != cur);
        tgl      = chg && (({1'b0, deb[pk]} + 5'd1) >= 5'(DEB_SCANS));
        rep_tgt  = rep_ph ? PW'(REP_RATE) : PW'(REP_DELAY);
        rep_step = proc && rep_act && repeat_en && (pk == rep_key)
                   && cur && !tgl;
        rep_hit  = rep_step && (PW'(rep_cnt + 1'b1) == rep_tgt);
        push     = 1'b0;
        push_ev  = '{code: pk, kind: 2'b00};
        unique case (1'b1)
            (tgl && raw): begin
                push         = 1'b1;
                push_ev.kind = 2'b01;
            end
            (tgl && !raw): begin
                push         = (REL_EVENTS != 0);
                push_ev.kind = 2'b10;
            end
            rep_hit: begin
                push         = 1'b1;
                push_ev.kind = 2'b11;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_down <= '0;
            for (int i = 0; i < NK; i++)
                deb[i] <= '0;
        end else if (proc) begin
            if (!chg) begin
                deb[pk] <= '0;
            end else if (tgl) begin
                deb[pk]      <= '0;
                key_down[pk] <= ~key_down[pk];
            end else begin
                deb[pk] <= deb[pk] + 1'b1;
            end
        end
    end

    // Repeat tracker: first gap is REP_DELAY scans, then REP_RATE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rep_key <= '0;
            rep_act <= 1'b0;
            rep_ph  <= 1'b0;
            rep_cnt <= '0;
        end else if (tgl && raw) begin
            rep_key <= pk;
            rep_act <= 1'b1;
            rep_ph  <= 1'b0;
            rep_cnt <= '0;
        end else if (tgl && !raw && pk == rep_key) begin
            rep_act <= 1'b0;
            rep_ph  <= 1'b0;
            rep_cnt <= '0;
        end else if (!repeat_en) begin
            rep_ph  <= 1'b0;
            rep_cnt <= '0;
        end else if (rep_hit) begin
            rep_ph  <= 1'b1;
            rep_cnt <= '0;
        end else if (rep_step) begin
            rep_cnt <= rep_cnt + 1'b1;
        end
    end

    assign full = (cnt == (AW + 1)'(FIFO_DEPTH));
    assign pop  = ev.ev_valid && ev.ev_ready;
    assign wr   = push && (!full || pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (wr) begin
                mem[wp] <= push_ev;
                wp      <= wp + 1'b1;
            end
            if (pop)
                rp <= rp + 1'b1;
            if (wr && !pop)
                cnt <= cnt + 1'b1;
            else if (!wr && pop)
                cnt <= cnt - 1'b1;
            if (push && full && !pop)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end

    assign ev.ev_valid = (cnt != '0);
    assign ev.ev_code  = mem[rp].code;
    assign ev.ev_kind  = mem[rp].kind;
endmodule

// File: tb/tb_keypad_scan_q.sv
// Directed bench for keypad_scan_q: keypad matrix model,
// event log with cycle stamps, hand-computed expectations.
module tb_keypad_scan_q;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int SDIV = 64;
    localparam int SCAN = ROWS * SDIV;

    typedef struct {
        int     code;
        int     kind;
        longint t;
    } rec_t;

    logic            clk;
    logic            rst;
    logic [ROWS-1:0] rkey;
    logic [COLS-1:0] ckey;
    logic            repeat_en;
    logic            clr_ovf;
    logic [15:0]     key_down;
    logic            overflow;
    logic [15:0]     keys;

    int     nerr;
    int     nchk;
    longint cyc;
    rec_t   q[$];

    keypad_scan_q_if #(.CW(4)) evif ();

    keypad_scan_q dut (
        .clk      (clk),
        .rst      (rst),
        .rkey     (rkey),
        .ckey     (ckey),
        .repeat_en(repeat_en),
        .clr_ovf  (clr_ovf),
        .ev       (evif),
        .key_down (key_down),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pressed key pulls its column low while its row is driven.
    always_comb begin
        ckey = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (!rkey[r] && keys[r*COLS+c])
                    ckey[c] = 1'b0;
    end

    always @(negedge clk)
        if (rst && evif.ev_valid && evif.ev_ready)
            q.push_back('{code: int'(evif.ev_code),
                          kind: int'(evif.ev_kind), t: cyc});

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int qc(input int i);
        return (i < q.size()) ? q[i].code : -1;
    endfunction

    function automatic int qk(input int i);
        return (i < q.size()) ? q[i].kind : -1;
    endfunction

    function automatic longint qt(input int i);
        return (i < q.size()) ? q[i].t : -1;
    endfunction

    task automatic scans(input int n);
        repeat (n * SCAN) @(posedge clk);
        #1;
    endtask

    initial begin
        nerr = 0;
        nchk = 0;
        cyc = 0;
        rst = 1'b0;
        keys = '0;
        repeat_en = 1'b0;
        clr_ovf = 1'b0;
        evif.ev_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rkey", 64'(rkey), 64'hF);
        chk("rst_valid", 64'(evif.ev_valid), 0);
        chk("rst_code", 64'(evif.ev_code), 0);
        chk("rst_kind", 64'(evif.ev_kind), 0);
        chk("rst_keydown", 64'(key_down), 0);
        chk("rst_ovf", 64'(overflow), 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        chk("first_rkey", 64'(rkey), 64'hE);

        keys[9] = 1'b1;
        scans(6);
        chk("t1_n", 64'(q.size()), 1);
        chk("t1_code", 64'(qc(0)), 9);
        chk("t1_kind", 64'(qk(0)), 1);
        chk("t1_down", 64'(key_down[9]), 1);
        keys = '0;
        scans(6);
        chk("t1_rel_n", 64'(q.size()), 2);
        chk("t1_rel_code", 64'(qc(1)), 9);
        chk("t1_rel_kind", 64'(qk(1)), 2);
        chk("t1_rel_down", 64'(key_down), 0);
        q.delete();

        keys[5] = 1'b1;
        scans(3);
        keys[5] = 1'b0;
        scans(6);
        chk("t2_n", 64'(q.size()), 0);
        chk("t2_down", 64'(key_down[5]), 0);

        keys[6] = 1'b1;
        keys[4] = 1'b1;
        scans(6);
        chk("t3_n", 64'(q.size()), 2);
        chk("t3_c0", 64'(qc(0)), 4);
        chk("t3_k0", 64'(qk(0)), 1);
        chk("t3_c1", 64'(qc(1)), 6);
        chk("t3_k1", 64'(qk(1)), 1);
        keys = '0;
        scans(6);
        chk("t3_rel_n", 64'(q.size()), 4);
        chk("t3_rel_c2", 64'(qc(2)), 4);
        chk("t3_rel_c3", 64'(qc(3)), 6);
        chk("t3_rel_k3", 64'(qk(3)), 2);
        q.delete();

        evif.ev_ready = 1'b0;
        keys = 16'h01FF;
        scans(6);
        chk("t4_valid", 64'(evif.ev_valid), 1);
        chk("t4_ovf", 64'(overflow), 1);
        chk("t4_head", 64'(evif.ev_code), 0);
        chk("t4_down", 64'(key_down), 64'h01FF);
        @(posedge clk);
        #1 clr_ovf = 1'b1;
        @(posedge clk);
        #1 clr_ovf = 1'b0;
        chk("t4_clr", 64'(overflow), 0);
        evif.ev_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("t4_n", 64'(q.size()), 8);
        chk("t4_c0", 64'(qc(0)), 0);
        chk("t4_c7", 64'(qc(7)), 7);
        chk("t4_empty", 64'(evif.ev_valid), 0);
        keys = '0;
        scans(6);
        chk("t4_rel_down", 64'(key_down), 0);
        q.delete();

        repeat_en = 1'b1;
        keys[0] = 1'b1;
        scans(53);
        keys[0] = 1'b0;
        scans(10);
        chk("t5_n", 64'(q.size()), 5);
        chk("t5_k0", 64'(qk(0)), 1);
        chk("t5_k1", 64'(qk(1)), 3);
        chk("t5_k2", 64'(qk(2)), 3);
        chk("t5_k3", 64'(qk(3)), 3);
        chk("t5_k4", 64'(qk(4)), 2);
        chk("t5_c4", 64'(qc(4)), 0);
        chk("t5_d1", 64'(qt(1) - qt(0)), 64'(32 * SCAN));
        chk("t5_d2", 64'(qt(2) - qt(1)), 64'(8 * SCAN));
        chk("t5_d3", 64'(qt(3) - qt(2)), 64'(8 * SCAN));
        repeat_en = 1'b0;
        q.delete();

        evif.ev_ready = 1'b0;
        keys[1] = 1'b1;
        scans(6);
        chk("t6_pre_valid", 64'(evif.ev_valid), 1);
        chk("t6_pre_code", 64'(evif.ev_code), 1);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("t6_rkey", 64'(rkey), 64'hF);
        chk("t6_valid", 64'(evif.ev_valid), 0);
        chk("t6_code", 64'(evif.ev_code), 0);
        chk("t6_kind", 64'(evif.ev_kind), 0);
        chk("t6_down", 64'(key_down), 0);
        chk("t6_ovf", 64'(overflow), 0);
        keys = '0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_rkey_run", 64'(rkey), 64'hE);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
